count_enable_gen: RTL

Programmable enable-pulse generator that sits directly upstream of the mod-N counter and drives its `en` input. It divides the system clock by a programmable ratio and emits one-cycle enable pulses. It runs either continuously until stopped, or as a burst of a programmed number of pulses. Busy and done status go to the sequencing logic that starts and stops counting.

---
 rtl/count_enable_gen.sv | 114 +++++++++++
 1 files changed

// File: rtl/count_enable_gen.sv
// Generates one-cycle enable pulses every D clocks, either continuously or as a burst of L pulses.
// Latency: first pulse is registered D edges after the accepted start, and every D edges after that.
// Backpressure: none; start is honoured only in IDLE, and stop aborts RUN immediately without done.
module count_enable_gen #(
   parameter int DIV_WIDTH   = 8,
   parameter int BURST_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   mode,
   input  logic [DIV_WIDTH-1:0]   div,
   input  logic [BURST_WIDTH-1:0] burst_len,
   output logic                   en,
   output logic                   busy,
   output logic                   done,
   output logic [BURST_WIDTH-1:0] tick_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [DIV_WIDTH-1:0]   DIV_ONE   = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [BURST_WIDTH-1:0] BURST_ONE = {{(BURST_WIDTH-1){1'b0}}, 1'b1};

   state_t                 state;
   logic                   mode_q;
   logic [DIV_WIDTH-1:0]   div_q;
   logic [BURST_WIDTH-1:0] len_q;
   logic [DIV_WIDTH-1:0]   presc;

   // Last prescaler value before a wrap, and the pulse count after the next pulse.
   logic [DIV_WIDTH-1:0]   div_last;
   logic [BURST_WIDTH-1:0] tick_next;
   logic                   wrap;

   // Derived compare values for the prescaler wrap and burst end.
   always_comb begin
      div_last  = div_q - DIV_ONE;
      tick_next = tick_cnt + BURST_ONE;
      wrap      = (presc == div_last);
   end

   // Control FSM with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         mode_q   <= 1'b0;
         div_q    <= DIV_ONE;
         len_q    <= BURST_ONE;
         presc    <= '0;
         en       <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         tick_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               en   <= 1'b0;
               done <= 1'b0;
               busy <= 1'b0;
               // Stop has priority over a coincident start.
               if (start && !stop) begin
                  mode_q   <= mode;
                  // Zero ratio or length would never fire; treat them as one.
                  div_q    <= (div == '0) ? DIV_ONE : div;
                  len_q    <= (burst_len == '0) ? BURST_ONE : burst_len;
                  presc    <= '0;
                  tick_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= S_RUN;
               end
            end
            S_RUN: begin
               done <= 1'b0;
               if (stop) begin
                  // Abort: a pulse due on this edge is suppressed, no done.
                  en    <= 1'b0;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else if (wrap) begin
                  presc    <= '0;
                  en       <= 1'b1;
                  tick_cnt <= tick_next;
                  if (mode_q && (tick_next == len_q)) begin
                     state <= S_DONE;
                  end
               end else begin
                  presc <= presc + DIV_ONE;
                  en    <= 1'b0;
               end
            end
            S_DONE: begin
               // Busy stays up through the final pulse and drops together with done.
               en    <= 1'b0;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               en    <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
